// File: rtl/inst_rom_resp_pkg.sv
// Shared fetch-path constants and types for the instruction-fetch responder.
// Bus widths, enable/stall encodings and the fill FSM states live here.
package inst_rom_resp_pkg;

    localparam int unsigned InstAddrBus   = 32;
    localparam int unsigned InstBus       = 32;
    localparam int unsigned InstLineWords = 4;

    localparam logic [InstBus-1:0] ZeroWord = '0;
    localparam logic ChipEnable = 1'b1;
    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    typedef enum logic {
        FetchIdle,
        FetchFill
    } fetch_state_e;

endpackage

// File: rtl/inst_rom_resp_if.sv
// Backing-memory read channel: req/addr held by the requester until ack,
// read data valid in the ack cycle.
interface inst_rom_resp_if #(
    parameter int unsigned ADDR_W = 32
);

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/inst_rom_resp_line_buf.sv
// One-line instruction buffer: synchronous write port, combinational read port.
// Contents carry no reset; the owning tag/valid logic guards every read.
module inst_line_buf #(
    parameter  int unsigned LINE_WORDS = 4,
    localparam int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] line_q [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            line_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = line_q[ridx_i];

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-fetch responder: serves fetches from a one-line buffer and
// refills it from backing memory on a miss, stalling the core meanwhile.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int unsigned LINE_WORDS = InstLineWords,
    parameter int unsigned ADDR_W     = InstAddrBus
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rom_ce_i,
    input  logic [ADDR_W-1:0]  rom_addr_i,
    output logic [InstBus-1:0] rom_data_o,
    output logic               stallreq_o,
    inst_rom_resp_if.master    mem
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned LSB   = OFF_W + 2;
    localparam int unsigned TAG_W = ADDR_W - LSB;

    fetch_state_e      state_q, state_d;
    logic              valid_q, valid_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;

    logic [TAG_W-1:0]  addr_tag;
    logic [OFF_W-1:0]  addr_off;
    logic              unused_byte_sel;
    logic              enabled;
    logic              hit;
    logic              miss;
    logic              buf_we;
    logic [31:0]       buf_rdata;

    assign addr_tag        = rom_addr_i[ADDR_W-1:LSB];
    assign addr_off        = rom_addr_i[LSB-1:2];
    assign unused_byte_sel = ^rom_addr_i[1:0];

    assign enabled = (rom_ce_i == ChipEnable);
    assign hit     = enabled && valid_q && (tag_q == addr_tag);
    assign miss    = enabled && !hit;

    assign rom_data_o = hit ? buf_rdata : ZeroWord;
    assign stallreq_o = miss ? Stop : NoStop;

    assign mem.req  = req_q;
    assign mem.addr = maddr_q;

    // Only acks inside a fill write the line; stray acks in IDLE are dropped.
    assign buf_we = (state_q == FetchFill) && mem.ack;

    inst_line_buf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .widx_i  (cnt_q),
        .wdata_i (mem.rdata),
        .ridx_i  (addr_off),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FetchIdle;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            tag_q      <= '0;
            fill_tag_q <= '0;
            req_q      <= 1'b0;
            maddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            fill_tag_q <= fill_tag_d;
            req_q      <= req_d;
            maddr_q    <= maddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        fill_tag_d = fill_tag_q;
        req_d      = req_q;
        maddr_d    = maddr_q;

        unique case (state_q)
            FetchIdle: begin
                if (miss) begin
                    state_d    = FetchFill;
                    fill_tag_d = addr_tag;
                    valid_d    = 1'b0;
                    cnt_d      = '0;
                    req_d      = 1'b1;
                    maddr_d    = {addr_tag, {LSB{1'b0}}};
                end
            end
            FetchFill: begin
                // The latched line always completes, even if the fetch address moved.
                if (mem.ack) begin
                    cnt_d   = cnt_q + 1'b1;
                    maddr_d = maddr_q + ADDR_W'(4);
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        tag_d   = fill_tag_q;
                        valid_d = 1'b1;
                        req_d   = 1'b0;
                        state_d = FetchIdle;
                    end
                end
            end
            default: state_d = FetchIdle;
        endcase
    end

endmodule

// File: doc/inst_rom_resp.md
# inst_rom_resp

Instruction-fetch responder that sits on the core side of the instruction ROM port. It answers the core's fetch interface (`rom_ce`, `rom_addr`, `rom_data`) from a one-line instruction buffer. On a miss it fills the line from a slower backing memory over a req/ack handshake, and holds a stall request to `ctrl` until the fetched word is valid. It replaces the zero-latency ROM model so that the pipeline stall path is exercised by real fetch latency.

## Interface
Parameters:
- `LINE_WORDS`, 4: words per line buffer; power of two, minimum 2.
- `ADDR_W`, 32: fetch and memory address width (`InstAddrBus`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rom_ce_i`  in  1  fetch enable from `pc_reg`.
- `rom_addr_i`  in  ADDR_W  byte fetch address; bits [1:0] ignored.
- `rom_data_o`  out  32  instruction for `if_id`.
- `stallreq_o`  out  1  to `ctrl`; high while `rom_data_o` is not valid for `rom_addr_i`.
- `mem_req_o`  out  1  backing-memory read request.
- `mem_addr_o`  out  ADDR_W  word-aligned backing-memory address.
- `mem_ack_i`  in  1  read accepted; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  32  backing-memory read data.

## Operation
- **State:** `line[LINE_WORDS]`, `tag` (`rom_addr_i[ADDR_W-1:log2(LINE_WORDS)+2]`), `valid`, fill counter `cnt`, and FSM {IDLE, FILL}.
- **Hit:** `rom_ce_i` && `valid` && tag match.
  - `rom_data_o` = `line[rom_addr_i[log2(LINE_WORDS)+1:2]]`, combinational.
  - `stallreq_o` = 0.
- **Miss:** `rom_ce_i` && !hit.
  - `stallreq_o` = 1, combinational.
  - `rom_data_o` = `ZeroWord`.
- **`rom_ce_i` = 0:**
  - `rom_data_o` = `ZeroWord` and `stallreq_o` = 0.
  - No fill is started. A fill already in progress runs to completion.
- **IDLE → FILL**, on a miss in IDLE:
  - Latch the line base (address with low `log2(LINE_WORDS)+2` bits cleared) into the fill tag.
  - Clear `valid` and set `cnt` = 0.
  - Assert `mem_req_o` with `mem_addr_o` = base.
- **FILL:**
  - `mem_req_o` stays high and `mem_addr_o` stays stable until `mem_ack_i` is sampled high.
  - On each ack: `line[cnt]` ← `mem_rdata_i`, `cnt`++, `mem_addr_o` += 4.
  - On the ack with `cnt` = LINE_WORDS-1: `tag` ← fill tag, `valid` ← 1, `mem_req_o` ← 0, next state IDLE.
  - Fill order is sequential from the base; there is no critical-word-first.
- **Address change mid-fill:** the fill is not aborted. It completes for the latched line, then the new address is re-evaluated in IDLE.
- **`mem_ack_i` outside FILL:** ignored; no state change.
- **Reset (any time, including mid-fill):**
  - `valid` = 0, FSM = IDLE, `cnt` = 0.
  - `mem_req_o` = 0 and `mem_addr_o` = 0, effective immediately (asynchronously).
  - `line` contents are don't-care.

## Timing
- **Reset values:** `rom_data_o` = 0, `stallreq_o` = 0 (`valid` = 0 and `ce` is low during reset in the core), `mem_req_o` = 0, `mem_addr_o` = 0.
- **Hit latency:** 0 cycles, purely combinational from `rom_addr_i`.
- **Miss sequence:**
  - Cycle 0: miss detected, `stallreq_o` = 1.
  - Cycle 1: `mem_req_o` is high from cycle 1 onward.
  - With an ack every cycle, words are transferred in cycles 1..LINE_WORDS and `valid` rises at the edge ending cycle LINE_WORDS.
  - The hit occurs in cycle LINE_WORDS+1, with `stallreq_o` = 0.
  - Miss penalty is LINE_WORDS+1 cycles plus total ack wait states.
- **Handshake:** one word transfers per cycle in which `mem_req_o` && `mem_ack_i`. A requester never drops `mem_req_o` before an ack, except by reset.

## Structure
- Shared constants come from `defines.v`: `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`, `Stop`/`NoStop`.
- Add two constants there: `InstLineWords` (the default 4) and the FSM state encodings `FetchIdle` and `FetchFill`.
- One sub-module is natural: `inst_line_buf`.
  - Contents: LINE_WORDS×32 storage, one synchronous write port (index, data, we), one combinational read port.
  - The FSM, tag/valid logic and handshake live in `inst_rom_resp`.

## Test plan
- **Cold miss:** reset, `ce` = 1, addr 0x0; memory acks every cycle returning 0x11, 0x22, 0x33, 0x44.
  - Requests go to addresses 0x0, 0x4, 0x8, 0xC.
  - `stallreq_o` is high for 5 cycles.
  - Then addr 0x4 gives `rom_data_o` = 0x22 with `stallreq_o` = 0.
- **Wait states:** ack arrives 3 cycles after each request.
  - `mem_addr_o` is stable while un-acked.
  - Total stall = 1 + 4×3 cycles.
  - Final line contents are correct.
- **Line crossing:** after the line at 0x0 is filled, addr 0xC hits (0x44, no stall); addr 0x10 misses.
  - The fill requests 0x10..0x1C.
  - Afterwards 0x0 misses again because the tag was replaced.
- **Address change mid-fill:** switch addr from 0x0 to 0x20 after 2 acks.
  - The fill at 0x0 completes (4 acks).
  - A new fill at 0x20 starts the cycle after returning to IDLE.
  - `stallreq_o` stays high throughout.
- **Chip enable low:** `ce` = 0 with an arbitrary addr.
  - `rom_data_o` = 0, `stallreq_o` = 0, `mem_req_o` never asserted.
  - A spurious `mem_ack_i` pulse changes nothing.
- **Reset mid-fill:** assert `rst` low after 2 acks.
  - `mem_req_o` drops without waiting for a clock edge.
  - After release, addr 0x0 misses again and performs a full 4-word refill.
